// File: rtl/msx_ram_arbiter.sv
// msx_ram_arbiter: shares one external RAM port between the CPU (priority) and a DMA/loader port,
// with DMA anti-starvation and a ram_ready timeout.
module msx_ram_arbiter #(
    parameter int ADDR_W       = 27,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 63
) (
    input  logic              clk21m,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rnw,
    output logic              cpu_ack,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_wait_n,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    input  logic              dma_rnw,
    output logic              dma_ack,
    output logic [7:0]        dma_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic              ram_rnw,
    output logic              ram_ce,
    input  logic              ram_ready,
    input  logic [7:0]        ram_dout,
    output logic              timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t     state, state_next;
    logic       owner;
    logic [7:0] starve_cnt, timer;
    logic       dma_win, grant, timed_out;

    assign dma_win   = dma_req & (~cpu_req | starve_cnt == 8'(STARVE_LIMIT));
    assign grant     = state == S_IDLE & (cpu_req | dma_req);
    assign timed_out = state == S_WAIT & ~ram_ready & timer == 8'(TIMEOUT - 1);

    assign ram_ce     = state == S_ISSUE;
    assign cpu_ack    = state == S_DONE & ~owner;
    assign dma_ack    = state == S_DONE & owner;
    assign cpu_wait_n = ~(reset_n & cpu_req & ~cpu_ack);

    always_ff @(posedge clk21m or negedge reset_n)
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;

    always_comb begin
        state_next = state;
        state_next = state == S_IDLE  ? (grant ? S_ISSUE : S_IDLE) :
                     state == S_ISSUE ? S_WAIT :
                     state == S_WAIT  ? ((ram_ready | timed_out) ? S_DONE : S_WAIT) :
                                        S_IDLE;
    end

    always_ff @(posedge clk21m or negedge reset_n) begin
        if (!reset_n) begin
            owner       <= 1'b0;
            ram_addr    <= '0;
            ram_din     <= 8'h00;
            ram_rnw     <= 1'b1;
            cpu_rdata   <= 8'hFF;
            dma_rdata   <= 8'hFF;
            starve_cnt  <= 8'd0;
            timer       <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            if (grant) begin
                owner    <= dma_win;
                ram_addr <= dma_win ? dma_addr : cpu_addr;
                ram_din  <= dma_win ? dma_wdata : cpu_wdata;
                ram_rnw  <= dma_win ? dma_rnw : cpu_rnw;
                // a CPU grant only happens below the limit while DMA waits, so +1 never overshoots
                starve_cnt <= (~dma_win & dma_req) ? starve_cnt + 8'd1 : 8'd0;
            end
            if (state == S_ISSUE) timer <= 8'd0;
            if (state == S_WAIT) begin
                timer <= timer + 8'd1;
                if (ram_ready & ram_rnw) begin
                    if (owner) dma_rdata <= ram_dout;
                    else       cpu_rdata <= ram_dout;
                end
                if (timed_out) begin
                    timeout_err <= 1'b1;
                    if (ram_rnw & owner)  dma_rdata <= 8'hFF;
                    if (ram_rnw & ~owner) cpu_rdata <= 8'hFF;
                end
            end
        end
    end
endmodule

// File: tb/tb_msx_ram_arbiter.sv
// tb_msx_ram_arbiter: directed tests of grant order, starvation, timeout, reset abort and throughput.
module tb_msx_ram_arbiter;
    logic        clk21m = 1'b0, reset_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_rnw = 1'b1, dma_req = 1'b0, dma_rnw = 1'b1, ram_ready = 1'b0;
    logic [26:0] cpu_addr = '0, dma_addr = '0;
    logic [7:0]  cpu_wdata = 8'h00, dma_wdata = 8'h00, ram_dout = 8'h00;
    logic        cpu_ack, cpu_wait_n, dma_ack, ram_rnw, ram_ce, timeout_err;
    logic [7:0]  cpu_rdata, dma_rdata, ram_din;
    logic [26:0] ram_addr;
    int vectors = 0, miscompares = 0;

    msx_ram_arbiter dut (
        .clk21m(clk21m), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rnw(cpu_rnw),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_wait_n(cpu_wait_n),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_rnw(dma_rnw),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_rnw(ram_rnw), .ram_ce(ram_ce),
        .ram_ready(ram_ready), .ram_dout(ram_dout), .timeout_err(timeout_err)
    );

    always #5 clk21m = ~clk21m;

    task automatic test_reset;
        reset_n = 1'b0;
        cpu_req = 1'b1;
        repeat (2) @(negedge clk21m);
        #1;
        vectors++; if (cpu_wait_n !== 1'b1) begin miscompares++; $display("FAIL reset_wait_n got %b want 1", cpu_wait_n); end
        vectors++; if ({ram_ce, ram_rnw, ram_addr, ram_din} !== {1'b0, 1'b1, 27'd0, 8'd0}) begin
            miscompares++; $display("FAIL reset_ram got ce=%b rnw=%b addr=%h din=%h want 0/1/0/0", ram_ce, ram_rnw, ram_addr, ram_din); end
        vectors++; if ({cpu_ack, dma_ack, timeout_err} !== 3'b000) begin
            miscompares++; $display("FAIL reset_flags got %b%b%b want 000", cpu_ack, dma_ack, timeout_err); end
        vectors++; if ({cpu_rdata, dma_rdata} !== 16'hFFFF) begin
            miscompares++; $display("FAIL reset_rdata got %h/%h want FF/FF", cpu_rdata, dma_rdata); end
        cpu_req = 1'b0;
        @(negedge clk21m);
        reset_n = 1'b1;
    endtask

    task automatic test_cpu_read;
        @(negedge clk21m);
        cpu_addr = 27'h100; cpu_rnw = 1'b1; cpu_req = 1'b1;
        #1;
        vectors++; if (cpu_wait_n !== 1'b0) begin miscompares++; $display("FAIL rd_wait_req got %b want 0", cpu_wait_n); end
        @(negedge clk21m);
        vectors++; if ({ram_ce, ram_rnw, ram_addr} !== {1'b1, 1'b1, 27'h100}) begin
            miscompares++; $display("FAIL rd_issue got ce=%b rnw=%b addr=%h want 1/1/100", ram_ce, ram_rnw, ram_addr); end
        @(negedge clk21m);
        vectors++; if ({ram_ce, cpu_ack, cpu_wait_n} !== 3'b000) begin
            miscompares++; $display("FAIL rd_wait1 got ce=%b ack=%b wait_n=%b want 000", ram_ce, cpu_ack, cpu_wait_n); end
        ram_ready = 1'b1; ram_dout = 8'h5A;
        @(negedge clk21m);
        ram_ready = 1'b0;
        vectors++; if ({cpu_ack, dma_ack, cpu_wait_n, cpu_rdata} !== {3'b101, 8'h5A}) begin
            miscompares++; $display("FAIL rd_done got ack=%b dack=%b wait_n=%b rdata=%h want 1/0/1/5A", cpu_ack, dma_ack, cpu_wait_n, cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk21m);
        vectors++; if ({cpu_ack, dma_ack, cpu_wait_n, cpu_rdata} !== {3'b001, 8'h5A}) begin
            miscompares++; $display("FAIL rd_after got ack=%b dack=%b wait_n=%b rdata=%h want 0/0/1/5A", cpu_ack, dma_ack, cpu_wait_n, cpu_rdata); end
        ram_ready = 1'b1; ram_dout = 8'h00;
        @(negedge clk21m);
        ram_ready = 1'b0;
        @(negedge clk21m);
        vectors++; if ({ram_ce, cpu_ack, dma_ack, cpu_rdata} !== {3'b000, 8'h5A}) begin
            miscompares++; $display("FAIL stray_ready got ce=%b ack=%b dack=%b rdata=%h want 0/0/0/5A", ram_ce, cpu_ack, dma_ack, cpu_rdata); end
    endtask

    task automatic test_simultaneous;
        @(negedge clk21m);
        cpu_addr = 27'h0A1; cpu_rnw = 1'b1; cpu_req = 1'b1;
        dma_addr = 27'h0B1; dma_wdata = 8'h33; dma_rnw = 1'b0; dma_req = 1'b1;
        @(negedge clk21m);
        vectors++; if ({ram_ce, ram_addr} !== {1'b1, 27'h0A1}) begin
            miscompares++; $display("FAIL sim_cpu_first got ce=%b addr=%h want 1/0A1", ram_ce, ram_addr); end
        @(negedge clk21m);
        ram_ready = 1'b1; ram_dout = 8'h11;
        @(negedge clk21m);
        ram_ready = 1'b0;
        vectors++; if ({ram_ce, cpu_ack, dma_ack, cpu_rdata} !== {3'b010, 8'h11}) begin
            miscompares++; $display("FAIL sim_cpu_done got ce=%b ack=%b dack=%b rdata=%h want 0/1/0/11", ram_ce, cpu_ack, dma_ack, cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk21m);
        vectors++; if ({ram_ce, cpu_ack, dma_ack} !== 3'b000) begin
            miscompares++; $display("FAIL sim_idle got ce=%b ack=%b dack=%b want 000", ram_ce, cpu_ack, dma_ack); end
        @(negedge clk21m);
        vectors++; if ({ram_ce, ram_rnw, ram_addr, ram_din} !== {2'b10, 27'h0B1, 8'h33}) begin
            miscompares++; $display("FAIL sim_dma_issue got ce=%b rnw=%b addr=%h din=%h want 1/0/0B1/33", ram_ce, ram_rnw, ram_addr, ram_din); end
        @(negedge clk21m);
        ram_ready = 1'b1; ram_dout = 8'h44;
        @(negedge clk21m);
        ram_ready = 1'b0;
        vectors++; if ({ram_ce, cpu_ack, dma_ack, dma_rdata} !== {3'b001, 8'hFF}) begin
            miscompares++; $display("FAIL sim_dma_done got ce=%b ack=%b dack=%b rdata=%h want 0/0/1/FF", ram_ce, cpu_ack, dma_ack, dma_rdata); end
        dma_req = 1'b0;
        @(negedge clk21m);
        vectors++; if ({ram_ce, dma_ack} !== 2'b00) begin
            miscompares++; $display("FAIL sim_end got ce=%b dack=%b want 00", ram_ce, dma_ack); end
    endtask

    task automatic test_starvation;
        int g;
        logic prev_ce, done;
        g = 0; prev_ce = 1'b0; done = 1'b0;
        cpu_addr = 27'h200; cpu_rnw = 1'b1; dma_addr = 27'h300; dma_rnw = 1'b1; ram_dout = 8'h77;
        @(negedge clk21m);
        cpu_req = 1'b1; dma_req = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk21m);
            ram_ready = prev_ce;
            prev_ce = ram_ce;
            if (ram_ce) begin
                vectors++; if (ram_addr !== ((g == 8 || g == 17) ? 27'h300 : 27'h200)) begin
                    miscompares++; $display("FAIL starve_grant%0d got addr=%h want %h", g, ram_addr, (g == 8 || g == 17) ? 27'h300 : 27'h200); end
                g++;
            end
            if (dma_ack && g == 18) done = 1'b1;
        end
        cpu_req = 1'b0; dma_req = 1'b0; ram_ready = 1'b0;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL starve_bound got grants=%0d want 18 within budget", g); end
        vectors++; if ({cpu_rdata, dma_rdata} !== 16'h7777) begin
            miscompares++; $display("FAIL starve_rdata got %h/%h want 77/77", cpu_rdata, dma_rdata); end
    endtask

    task automatic test_timeout;
        int n, ces;
        logic prev_ce;
        @(negedge clk21m);
        dma_addr = 27'h1FFFFFF; dma_wdata = 8'hA5; dma_rnw = 1'b0; dma_req = 1'b1;
        n = 0; ces = 0;
        while (n < 200 && dma_ack !== 1'b1) begin
            @(negedge clk21m);
            n++;
            if (ram_ce) ces++;
            if (n == 64) begin
                vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_early got %b want 0", timeout_err); end
            end
        end
        dma_req = 1'b0;
        vectors++; if (n != 65) begin miscompares++; $display("FAIL to_latency got %0d want 65", n); end
        vectors++; if (ces != 1) begin miscompares++; $display("FAIL to_ce_count got %0d want 1", ces); end
        vectors++; if ({timeout_err, ram_rnw, ram_addr, ram_din, dma_rdata} !== {2'b10, 27'h1FFFFFF, 8'hA5, 8'h77}) begin
            miscompares++; $display("FAIL to_state got err=%b rnw=%b addr=%h din=%h rdata=%h want 1/0/1FFFFFF/A5/77",
                                    timeout_err, ram_rnw, ram_addr, ram_din, dma_rdata); end
        @(negedge clk21m);
        cpu_addr = 27'h020; cpu_rnw = 1'b1; cpu_req = 1'b1;
        n = 0;
        while (n < 200 && cpu_ack !== 1'b1) begin @(negedge clk21m); n++; end
        cpu_req = 1'b0;
        vectors++; if (n != 65 || cpu_rdata !== 8'hFF) begin
            miscompares++; $display("FAIL to_cpu_read got latency=%0d rdata=%h want 65/FF", n, cpu_rdata); end
        @(negedge clk21m);
        cpu_addr = 27'h030; cpu_req = 1'b1; ram_dout = 8'h3C;
        n = 0; prev_ce = 1'b0;
        while (n < 50 && cpu_ack !== 1'b1) begin
            @(negedge clk21m);
            n++;
            ram_ready = prev_ce;
            prev_ce = ram_ce;
        end
        cpu_req = 1'b0; ram_ready = 1'b0;
        vectors++; if (n != 3 || cpu_rdata !== 8'h3C || timeout_err !== 1'b1) begin
            miscompares++; $display("FAIL to_recover got latency=%0d rdata=%h err=%b want 3/3C/1", n, cpu_rdata, timeout_err); end
    endtask

    task automatic test_reset_in_wait;
        @(negedge clk21m);
        cpu_addr = 27'h040; cpu_rnw = 1'b1; cpu_req = 1'b1;
        @(negedge clk21m);
        @(negedge clk21m);
        reset_n = 1'b0;
        #1;
        vectors++; if ({cpu_wait_n, ram_ce, ram_rnw, ram_addr, ram_din, cpu_ack, timeout_err, cpu_rdata} !== {3'b101, 27'd0, 8'd0, 2'b00, 8'hFF}) begin
            miscompares++; $display("FAIL rst_wait got wait_n=%b ce=%b rnw=%b addr=%h din=%h ack=%b err=%b rdata=%h want 1/0/1/0/0/0/0/FF",
                                    cpu_wait_n, ram_ce, ram_rnw, ram_addr, ram_din, cpu_ack, timeout_err, cpu_rdata); end
        cpu_req = 1'b0;
        @(negedge clk21m);
        reset_n = 1'b1; ram_ready = 1'b1; ram_dout = 8'h99;
        @(negedge clk21m);
        ram_ready = 1'b0;
        vectors++; if ({ram_ce, cpu_ack, cpu_rdata} !== {2'b00, 8'hFF}) begin
            miscompares++; $display("FAIL rst_late_ready got ce=%b ack=%b rdata=%h want 0/0/FF", ram_ce, cpu_ack, cpu_rdata); end
        cpu_addr = 27'h044; cpu_req = 1'b1;
        @(negedge clk21m);
        vectors++; if ({ram_ce, ram_addr} !== {1'b1, 27'h044}) begin
            miscompares++; $display("FAIL rst_idle got ce=%b addr=%h want 1/044", ram_ce, ram_addr); end
        @(negedge clk21m);
        ram_ready = 1'b1; ram_dout = 8'h12;
        @(negedge clk21m);
        ram_ready = 1'b0;
        vectors++; if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h12}) begin
            miscompares++; $display("FAIL rst_next_access got ack=%b rdata=%h want 1/12", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
    endtask

    task automatic test_back_to_back;
        int i, last_ce;
        logic prev_ce;
        i = 0; last_ce = -1; prev_ce = 1'b0;
        ram_dout = 8'hC3;
        @(negedge clk21m);
        dma_addr = 27'h500; dma_wdata = 8'h11; dma_rnw = 1'b0; dma_req = 1'b1;
        for (int n = 1; n < 100 && i < 3; n++) begin
            @(negedge clk21m);
            ram_ready = prev_ce;
            prev_ce = ram_ce;
            if (ram_ce) begin
                vectors++; if ({ram_rnw, ram_addr, ram_din} !== {1'b0, 27'(27'h500 + i), 8'(8'h11 * (i + 1))}) begin
                    miscompares++; $display("FAIL b2b_issue%0d got rnw=%b addr=%h din=%h want 0/%h/%h",
                                            i, ram_rnw, ram_addr, ram_din, 27'(27'h500 + i), 8'(8'h11 * (i + 1))); end
                if (last_ce >= 0) begin
                    vectors++; if (n - last_ce != 4) begin miscompares++; $display("FAIL b2b_spacing%0d got %0d want 4", i, n - last_ce); end
                end
                last_ce = n;
            end
            if (dma_ack) begin
                i++;
                dma_addr = 27'(27'h500 + i);
                dma_wdata = 8'(8'h11 * (i + 1));
                if (i == 3) dma_req = 1'b0;
            end
        end
        ram_ready = 1'b0; dma_req = 1'b0;
        vectors++; if (i != 3 || dma_rdata !== 8'hFF) begin
            miscompares++; $display("FAIL b2b_end got acks=%0d rdata=%h want 3/FF", i, dma_rdata); end
    endtask

    initial begin
        test_reset;
        test_cpu_read;
        test_simultaneous;
        test_starvation;
        test_timeout;
        test_reset_in_wait;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
